slow_clock_period_monitor: RTL and testbench

- Receiving end of the binary ripple clock divider: runs on the fast system clock and observes the divided clock, which is asynchronous to it because it is ripple-generated.
- Synchronises the divided clock, emits a one-cycle TICK per rising edge, measures its period in fast-clock cycles and flags a stalled divider.
- Sits beside the divider so downstream logic consumes TICK as a synchronous enable instead of clocking on the divided net.

---
 rtl/slow_clock_period_monitor.sv | 170 +++++++++++++++++
 tb/tb_slow_clock_period_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/slow_clock_period_monitor.sv
// Fast-clock observer for a ripple-divided clock: synchronises it, emits a TICK per rising edge,
// measures the period and flags a stalled divider. Define SLOWCLK_DUTY_MEASURE_EN to add high_time_o.
module slow_clock_period_monitor #(
   parameter int CNT_WIDTH     = 20,
   parameter int SYNC_STAGES   = 2,
   parameter int TIMEOUT_LIMIT = 524287
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 slowclk_i,
   input  logic                 enable_i,
   output logic                 tick_o,
   output logic [CNT_WIDTH-1:0] period_o,
   output logic                 period_valid_o,
   output logic                 timeout_o,
`ifdef SLOWCLK_DUTY_MEASURE_EN
   output logic [CNT_WIDTH-1:0] high_time_o,
`endif
   output logic                 locked_o
);

   // state   | meaning
   // IDLE    | disabled, counter held at 0
   // ARM     | waiting for the first edge; its interval is discarded
   // MEASURE | counting cycles between edges, reporting each period
   // STALL   | no edge within TIMEOUT_LIMIT cycles; waiting for one
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;
   localparam logic [1:0] ST_STALL   = 2'd3;

   localparam logic [CNT_WIDTH-1:0] LIMIT_C = TIMEOUT_LIMIT[CNT_WIDTH-1:0];
   localparam logic [CNT_WIDTH-1:0] ONE_C   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   tick_q;

   logic [1:0]             state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]   period_q, period_d;
   logic                   pv_q, pv_d;
   logic                   timeout_q, timeout_d;
   logic                   locked_q, locked_d;
   logic [CNT_WIDTH-1:0]   cnt_inc;
   logic                   at_limit;

   // edge_q is the synchronised clock aligned with tick_q
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= '0;
         edge_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], slowclk_i};
         edge_q <= sync_q[SYNC_STAGES-1];
         tick_q <= sync_q[SYNC_STAGES-1] & ~edge_q & enable_i;
      end
   end

   assign at_limit = (cnt_q == LIMIT_C);
   assign cnt_inc  = at_limit ? cnt_q : cnt_q + ONE_C;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      pv_d      = 1'b0;
      timeout_d = timeout_q;
      locked_d  = locked_q;
      if (!enable_i) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         timeout_d = 1'b0;
         locked_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d   = '0;
               state_d = ST_ARM;
            end
            ST_ARM, ST_MEASURE: begin
               if (tick_q) begin
                  cnt_d   = ONE_C;
                  state_d = ST_MEASURE;
                  if (state_q == ST_MEASURE) begin
                     period_d = cnt_q;
                     pv_d     = 1'b1;
                     locked_d = 1'b1;
                  end
               end else if (at_limit) begin
                  state_d   = ST_STALL;
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_STALL: begin
               timeout_d = 1'b1;
               if (tick_q) begin
                  timeout_d = 1'b0;
                  cnt_d     = ONE_C;
                  state_d   = ST_MEASURE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         pv_q      <= 1'b0;
         timeout_q <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         pv_q      <= pv_d;
         timeout_q <= timeout_d;
         locked_q  <= locked_d;
      end
   end

`ifdef SLOWCLK_DUTY_MEASURE_EN
   logic [CNT_WIDTH-1:0] hc_q, hc_d;
   logic [CNT_WIDTH-1:0] high_q, high_d;

   // The tick cycle itself is always a high cycle, so a new interval starts at 1.
   always_comb begin
      hc_d   = hc_q;
      high_d = high_q;
      if (!enable_i || state_q == ST_IDLE) begin
         hc_d = '0;
      end else if (tick_q) begin
         hc_d = ONE_C;
         if (state_q == ST_MEASURE) high_d = hc_q;
      end else if (hc_q != LIMIT_C) begin
         hc_d = hc_q + {{(CNT_WIDTH-1){1'b0}}, edge_q};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hc_q   <= '0;
         high_q <= '0;
      end else begin
         hc_q   <= hc_d;
         high_q <= high_d;
      end
   end

   assign high_time_o = high_q;
`endif

   assign tick_o         = tick_q;
   assign period_o       = period_q;
   assign period_valid_o = pv_q;
   assign timeout_o      = timeout_q;
   assign locked_o       = locked_q;

endmodule

// File: tb/tb_slow_clock_period_monitor.sv
// Bench for slow_clock_period_monitor: edge-history model compared every cycle, plus literal checks.
module tb_slow_clock_period_monitor;
   localparam int CW  = 8;
   localparam int SS  = 2;
   localparam int LIM = 200;
`ifdef SLOWCLK_DUTY_MEASURE_EN
   localparam int HI40 = 10;
`else
   localparam int HI40 = 20;
`endif

   logic clk_sys = 1'b0;
   logic rst_n, slowclk, enable;
   logic tick, pv, timeout, locked;
   logic [CW-1:0] period;
`ifdef SLOWCLK_DUTY_MEASURE_EN
   logic [CW-1:0] high_time;
`endif

   slow_clock_period_monitor #(.CNT_WIDTH(CW), .SYNC_STAGES(SS), .TIMEOUT_LIMIT(LIM)) dut (
      .clk_i(clk_sys), .rst_n_i(rst_n), .slowclk_i(slowclk), .enable_i(enable),
      .tick_o(tick), .period_o(period), .period_valid_o(pv), .timeout_o(timeout),
`ifdef SLOWCLK_DUTY_MEASURE_EN
      .high_time_o(high_time),
`endif
      .locked_o(locked));

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int failures = 0;
   int kcyc = 0;
   int base_c = 0;
   bit hist[1024];

   // model state: edge history and distances between accepted ticks
   bit m_tick, m_pv, m_timeout, m_locked;
   int m_period, m_high;
   bit running, stalled;
   int ref_c, arm_c;

   function automatic bit s_at(int j);
      return (j >= base_c) ? hist[j % 1024] : 1'b0;
   endfunction

   always @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         foreach (hist[i]) hist[i] = 1'b0;
         base_c = kcyc + 1;
         m_tick = 0; m_pv = 0; m_timeout = 0; m_locked = 0;
         m_period = 0; m_high = 0;
         running = 0; stalled = 0; ref_c = -1; arm_c = 0;
      end else begin
         bit tick_prev;
         kcyc++;
         hist[kcyc % 1024] = slowclk;
         tick_prev = m_tick;
         m_tick = enable && s_at(kcyc - SS) && !s_at(kcyc - SS - 1);
         m_pv = 0;
         if (!enable) begin
            running = 0; stalled = 0; ref_c = -1;
            m_timeout = 0; m_locked = 0;
         end else if (!running) begin
            running = 1; stalled = 0; ref_c = -1; arm_c = kcyc;
         end else if (tick_prev) begin
            if (ref_c >= 0 && !stalled) begin
               int sum;
               sum = 0;
               for (int c = ref_c; c <= kcyc - 2; c++) sum += int'(s_at(c - SS));
               m_period = (kcyc - 1) - ref_c;
               m_high = (sum > LIM) ? LIM : sum;
               m_pv = 1;
               m_locked = 1;
            end
            ref_c = kcyc - 1;
            stalled = 0;
            m_timeout = 0;
         end else if (!stalled) begin
            int elapsed;
            elapsed = (ref_c >= 0) ? (kcyc - 1 - ref_c) : (kcyc - 1 - arm_c);
            if (elapsed >= LIM) begin
               stalled = 1; m_timeout = 1; m_locked = 0;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, kcyc);
      end
   endtask

   // DUT event log used by the literal checks
   int n_ticks = 0, n_pv = 0;
   int dut_first_tick = -1, dut_last_tick = -1, timeout_rise = -1;
   bit prev_to = 0;

   always @(negedge clk_sys) begin
      chk("tick", int'(tick), int'(m_tick));
      chk("period_valid", int'(pv), int'(m_pv));
      chk("period", int'(period), m_period);
      chk("timeout", int'(timeout), int'(m_timeout));
      chk("locked", int'(locked), int'(m_locked));
`ifdef SLOWCLK_DUTY_MEASURE_EN
      if (pv) chk("high_time", int'(high_time), m_high);
`endif
      if (tick) begin
         n_ticks++;
         dut_last_tick = kcyc;
         if (dut_first_tick < 0) dut_first_tick = kcyc;
      end
      if (pv) n_pv++;
      if (timeout && !prev_to) timeout_rise = kcyc;
      prev_to = timeout;
   end

   int ph = 0;
   bit mark_high = 0;
   int first_high = -1;

   task automatic step(input bit s);
      @(posedge clk_sys);
      #1;
      if (s && mark_high) begin
         first_high = kcyc + 1;
         mark_high = 0;
      end
      slowclk = s;
   endtask

   task automatic run_sq(input int per, input int hi, input int n);
      repeat (n) begin
         step(ph < hi);
         ph++;
         if (ph >= per) ph = 0;
      end
   endtask

   initial begin
      rst_n = 0; slowclk = 0; enable = 0;
      repeat (3) @(posedge clk_sys);
      #1 rst_n = 1;

      repeat (20) step(0);
      chk("idle_ticks", n_ticks, 0);
      chk("idle_period", int'(period), 0);
      chk("idle_locked", int'(locked), 0);

      // steady 40-cycle clock
      enable = 1;
      n_pv = 0; dut_first_tick = -1; mark_high = 1; ph = 0;
      run_sq(40, HI40, 240);
      chk("tick_latency", dut_first_tick - first_high, 2);
      chk("period_40", int'(period), 40);
      chk("locked_40", int'(locked), 1);
      chk("pv_count_40", n_pv, 5);
`ifdef SLOWCLK_DUTY_MEASURE_EN
      chk("high_time_10", int'(high_time), 10);
`endif

      // divider stalls
      repeat (250) step(0);
      chk("timeout_delay", timeout_rise - dut_last_tick, 201);
      chk("timeout_set", int'(timeout), 1);
      chk("stall_locked", int'(locked), 0);
      chk("stall_period", int'(period), 40);

      // restart: first tick clears timeout, second gives a period
      n_pv = 0; ph = 0;
      run_sq(40, HI40, 70);
      chk("restart_timeout", int'(timeout), 0);
      chk("restart_pv_count", n_pv, 1);
      chk("restart_period", int'(period), 40);

      // 40 -> 25 period change
      run_sq(40, HI40, 30);
      ph = 0;
      run_sq(25, 12, 200);
      chk("period_25", int'(period), 25);

      // back to 40, then drop enable mid-period
      ph = 0;
      run_sq(40, HI40, 200);
      chk("period_back_40", int'(period), 40);
      run_sq(40, HI40, 15);
      enable = 0;
      n_pv = 0;
      run_sq(40, HI40, 10);
      chk("dis_locked", int'(locked), 0);
      chk("dis_pv_count", n_pv, 0);
      chk("dis_period", int'(period), 40);
      enable = 1;
      run_sq(40, HI40, 120);
      chk("reen_period", int'(period), 40);
      chk("reen_locked", int'(locked), 1);

      // async reset mid-period
      run_sq(40, HI40, 15);
      #3 rst_n = 0;
      #1;
      chk("rst_period", int'(period), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_tick", int'(tick), 0);
      repeat (2) @(posedge clk_sys);
      #1 rst_n = 1;
      run_sq(40, HI40, 30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
